// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - requester-side and arbiter-side view of the shared CPU bus arbitration signals
interface bus_arbiter_if #(
   parameter int NREQ  = 4,
   parameter int DST_W = 24
);
   logic [NREQ-1:0]       req;
   logic [5*NREQ-1:0]     src_sel;
   logic [DST_W*NREQ-1:0] dst_en;
   logic [NREQ-1:0]       gnt;
   logic [4:0]            bus_sel;
   logic [DST_W-1:0]      ld_en;
   logic                  busy;
   logic                  src_err;

   // master: the requesters; slave: the arbiter itself
   modport master (
      output req, src_sel, dst_en,
      input  gnt, bus_sel, ld_en, busy, src_err
   );

   modport slave (
      input  req, src_sel, dst_en,
      output gnt, bus_sel, ld_en, busy, src_err
   );
endinterface

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin owner of the 32-bit CPU bus with burst cap and load-enable qualification
module bus_arbiter #(
   parameter int NREQ      = 4,
   parameter int DST_W     = 24,
   parameter int MAX_BURST = 8
) (
   input  logic           clk,
   input  logic           clr,
   bus_arbiter_if.slave   bus
);

   localparam int OW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam logic [7:0]    LAST_BEAT  = 8'(MAX_BURST - 1);
   localparam logic [4:0]    SEL_NONE   = 5'h1f;
   localparam logic [4:0]    SEL_MAXLEG = 5'd23;
   localparam logic [OW-1:0] OWNER_LAST = OW'(NREQ - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      TURN = 2'd2
   } state_t;

   state_t            state, state_n;
   logic [OW-1:0]     owner, owner_n;
   logic [OW-1:0]     last_owner, last_owner_n;
   logic [7:0]        count, count_n;
   logic [NREQ-1:0]   gnt_q, gnt_n;
   logic              err_q, err_n;

   logic [4:0]        bus_sel_c;
   logic [DST_W-1:0]  ld_en_c;
   logic              busy_c;

   logic              cur_req;
   logic [4:0]        cur_src;
   logic [DST_W-1:0]  cur_dst;
   logic              cur_legal;
   logic [OW:0]       pick;

   // Scan from last_owner+1 upward with wrap; descending loop lets the nearest candidate win.
   function automatic logic [OW:0] rr_pick(input logic [NREQ-1:0] r, input logic [OW-1:0] last);
      logic [OW:0] res;
      int          idx;
      res = '0;
      for (int k = NREQ; k >= 1; k--) begin
         idx = (int'(last) + k) % NREQ;
         if (r[idx]) res = {1'b1, OW'(idx)};
      end
      return res;
   endfunction

   assign pick      = rr_pick(bus.req, last_owner);
   assign cur_req   = bus.req[owner];
   assign cur_src   = bus.src_sel[5*int'(owner) +: 5];
   assign cur_dst   = bus.dst_en[DST_W*int'(owner) +: DST_W];
   assign cur_legal = (cur_src <= SEL_MAXLEG);

   always_ff @(posedge clk or posedge clr) begin
      if (clr) begin
         state      <= IDLE;
         owner      <= '0;
         last_owner <= OWNER_LAST;
         count      <= '0;
         gnt_q      <= '0;
         err_q      <= 1'b0;
      end else begin
         state      <= state_n;
         owner      <= owner_n;
         last_owner <= last_owner_n;
         count      <= count_n;
         gnt_q      <= gnt_n;
         err_q      <= err_n;
      end
   end

   always_comb begin
      state_n      = state;
      owner_n      = owner;
      last_owner_n = last_owner;
      count_n      = count;
      gnt_n        = gnt_q;
      err_n        = err_q;
      bus_sel_c    = SEL_NONE;
      ld_en_c      = '0;
      busy_c       = 1'b0;

      case (state)
         IDLE: begin
            if (pick[OW]) begin
               state_n        = BUSY;
               owner_n        = pick[OW-1:0];
               count_n        = '0;
               gnt_n          = '0;
               gnt_n[pick[OW-1:0]] = 1'b1;
            end
         end

         BUSY: begin
            busy_c = 1'b1;
            if (cur_req) begin
               if (cur_legal) begin
                  bus_sel_c = cur_src;
                  ld_en_c   = cur_dst;
               end else begin
                  err_n = 1'b1;
               end
               count_n = count + 8'd1;
            end
            // Release either on a dropped request or after the last permitted beat.
            if (!cur_req || (count == LAST_BEAT)) begin
               state_n      = TURN;
               gnt_n        = '0;
               last_owner_n = owner;
               count_n      = '0;
            end
         end

         TURN: begin
            state_n = IDLE;
         end

         default: begin
            state_n = IDLE;
            gnt_n   = '0;
         end
      endcase
   end

   assign bus.gnt     = gnt_q;
   assign bus.src_err = err_q;
   assign bus.bus_sel = bus_sel_c;
   assign bus.ld_en   = ld_en_c;
   assign bus.busy    = busy_c;

endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - directed-vector bench for bus_arbiter
module tb_bus_arbiter;

   logic clk;
   logic clr;
   int   n_chk;
   int   n_pass;
   int   n_xfer;

   bus_arbiter_if #(.NREQ(4), .DST_W(24)) a ();
   bus_arbiter_if #(.NREQ(4), .DST_W(24)) b ();

   bus_arbiter #(.NREQ(4), .DST_W(24), .MAX_BURST(8)) dut8 (.clk(clk), .clr(clr), .bus(a));
   bus_arbiter #(.NREQ(4), .DST_W(24), .MAX_BURST(2)) dut2 (.clk(clk), .clr(clr), .bus(b));

   // Hand-derived round-robin timeline for req=1011 with a two-beat cap.
   logic [3:0] rr_gnt [0:13] = '{4'h0, 4'h1, 4'h1, 4'h0, 4'h0, 4'h2, 4'h2,
                                 4'h0, 4'h0, 4'h8, 4'h8, 4'h0, 4'h0, 4'h1};
   logic [4:0] rr_sel [0:13] = '{5'd31, 5'd1, 5'd1, 5'd31, 5'd31, 5'd2, 5'd2,
                                 5'd31, 5'd31, 5'd4, 5'd4, 5'd31, 5'd31, 5'd1};

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   initial begin
      n_chk = 0; n_pass = 0; n_xfer = 0;
      clr = 1'b0;
      a.req = '0; a.src_sel = '0; a.dst_en = '0;
      b.req = '0; b.src_sel = '0; b.dst_en = '0;
      #2 clr = 1'b1;
      tick();
      check("rst_gnt", 32'(a.gnt), 32'h0);
      check("rst_sel", 32'(a.bus_sel), 32'd31);
      check("rst_ld", 32'(a.ld_en), 32'h0);
      check("rst_busy", 32'(a.busy), 32'h0);
      check("rst_err", 32'(a.src_err), 32'h0);

      // reset mid-tenure
      clr = 1'b0;
      a.req = 4'b0001; a.src_sel[4:0] = 5'd5; a.dst_en[23:0] = 24'h8;
      tick(); #1;
      check("mid_gnt1", 32'(a.gnt), 32'h1);
      check("mid_busy1", 32'(a.busy), 32'h1);
      check("mid_sel1", 32'(a.bus_sel), 32'd5);
      check("mid_ld1", 32'(a.ld_en), 32'h8);
      tick(); tick(); #2;
      clr = 1'b1; #1;
      check("mid_rst_gnt", 32'(a.gnt), 32'h0);
      check("mid_rst_sel", 32'(a.bus_sel), 32'd31);
      check("mid_rst_ld", 32'(a.ld_en), 32'h0);
      check("mid_rst_busy", 32'(a.busy), 32'h0);
      a.req = 4'b1111;
      tick(); clr = 1'b0;
      tick();
      check("post_rst_gnt", 32'(a.gnt), 32'h1);
      a.req = 4'b0000; #1;
      check("drop_sel", 32'(a.bus_sel), 32'd31);
      check("drop_ld", 32'(a.ld_en), 32'h0);
      tick();
      check("turn_gnt", 32'(a.gnt), 32'h0);
      check("turn_busy", 32'(a.busy), 32'h0);
      tick();

      // single transfer PC -> MAR
      a.src_sel[4:0] = 5'd20; a.dst_en[23:0] = 24'h200000; a.req = 4'b0001;
      tick(); #1;
      check("one_sel", 32'(a.bus_sel), 32'd20);
      check("one_ld", 32'(a.ld_en), 32'h200000);
      tick();
      a.req = 4'b0000; #1;
      check("one_rel_sel", 32'(a.bus_sel), 32'd31);
      check("one_rel_ld", 32'(a.ld_en), 32'h0);
      check("one_rel_busy", 32'(a.busy), 32'h1);
      tick();
      check("one_turn_gnt", 32'(a.gnt), 32'h0);
      tick();

      // illegal source code
      a.src_sel[14:10] = 5'd27; a.dst_en[71:48] = 24'hffffff; a.req = 4'b0100;
      tick(); #1;
      check("ill_gnt", 32'(a.gnt), 32'h4);
      check("ill_sel", 32'(a.bus_sel), 32'd31);
      check("ill_ld", 32'(a.ld_en), 32'h0);
      check("ill_err0", 32'(a.src_err), 32'h0);
      tick();
      check("ill_err1", 32'(a.src_err), 32'h1);
      a.req = 4'b0000;
      tick(); tick();
      check("ill_err_held", 32'(a.src_err), 32'h1);
      #2 clr = 1'b1; #1;
      check("ill_err_clr", 32'(a.src_err), 32'h0);
      clr = 1'b0;
      tick();

      // burst cap: req2 alone for 20 cycles
      a.src_sel[14:10] = 5'd9; a.dst_en[71:48] = 24'h200; a.req = 4'b0100;
      for (int i = 0; i < 20; i++) begin
         #1;
         if (a.busy && a.bus_sel == 5'd9 && a.ld_en == 24'h200) n_xfer++;
         if (i == 8)  check("cap_busy8", 32'(a.busy), 32'h1);
         if (i == 9)  check("cap_turn_gnt", 32'(a.gnt), 32'h0);
         if (i == 11) check("cap_regnt", 32'(a.gnt), 32'h4);
         tick();
      end
      check("cap_xfers", 32'(n_xfer), 32'd16);
      a.req = 4'b0000;
      tick();

      // early drop with req1 waiting
      a.src_sel[4:0] = 5'd3; a.dst_en[23:0] = 24'h8;
      a.src_sel[9:5] = 5'd6; a.dst_en[47:24] = 24'h40;
      a.req = 4'b0011;
      tick(); #1;
      check("ed_sel1", 32'(a.bus_sel), 32'd3);
      tick(); #1;
      check("ed_ld2", 32'(a.ld_en), 32'h8);
      tick();
      a.req = 4'b0010; #1;
      check("ed_drop_sel", 32'(a.bus_sel), 32'd31);
      check("ed_drop_gnt", 32'(a.gnt), 32'h1);
      tick();
      check("ed_turn_gnt", 32'(a.gnt), 32'h0);
      tick();
      check("ed_idle_gnt", 32'(a.gnt), 32'h0);
      tick();
      check("ed_gnt1", 32'(a.gnt), 32'h2);
      a.src_sel[4:0] = 5'd27; #1;
      check("ed_sel_r1", 32'(a.bus_sel), 32'd6);
      check("ed_ld_r1", 32'(a.ld_en), 32'h40);
      check("ed_nonowner_err", 32'(a.src_err), 32'h0);
      a.req = 4'b0000;
      tick(); tick();

      // round robin, two-beat cap
      b.src_sel = {5'd4, 5'd0, 5'd2, 5'd1};
      b.dst_en  = {24'h8, 24'h0, 24'h4, 24'h2};
      b.req = 4'b1011;
      for (int i = 0; i < 14; i++) begin
         #1;
         check($sformatf("rr_gnt%0d", i), 32'(b.gnt), 32'(rr_gnt[i]));
         check($sformatf("rr_sel%0d", i), 32'(b.bus_sel), 32'(rr_sel[i]));
         tick();
      end
      b.req = 4'b0000;
      tick();

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
